pill_plant_sim: RTL
===================

# pill_plant_sim

Closed-loop stand-in for the bottling line's physical plant: the hopper gate and the bottle conveyor. It produces the hopper drop pulses and conveyor-ready level that the bottling controller consumes, and reacts to the controller's run and bottle-switch requests. It sits between the controller and the board switches, which inject refill, starvation and jam faults. It is used on-board for demos and in simulation as the controller's plant model.

## Interface
- DROP_PERIOD_MS, 1000, cycles between pill drops while dispensing (≥128)
- PULSE_MS, 10, high time of each hopper_level pulse (< DROP_PERIOD_MS)
- HOPPER_CAP, 200, pills held after reset or refill (1..255)
- SWITCH_MS, 2000, bottle-change travel time in cycles
- clk_1khz  in  1  sole clock, 1 kHz; 1 cycle = 1 ms
- clr  in  1  synchronous, active-high reset
- run  in  1  level; controller is in its filling state
- switch_req  in  1  one-cycle pulse; controller requests next bottle
- refill  in  1  one-cycle pulse; manual hopper refill
- starve  in  1  level; gate blocked, drops suppressed
- jam  in  1  level; conveyor jammed
- hopper_level  out  1  drop pulse; controller edge-detects the rising edge
- conveyor_signal  out  1  high = bottle in place, conveyor healthy
- bottle_busy  out  1  high while a switch or jam is in progress
- pills_left  out  8  pills remaining in hopper
- fill_cnt  out  10  pills dropped into current bottle, saturates at 999
- bottles_out  out  7  completed bottles, saturates at 99
- plant_state  out  3  encoded state, for the display mux

## Operation
- States: IDLE=0, DISPENSE=1, SWITCH=2, EMPTY=3, JAMMED=4.
- IDLE -> DISPENSE when run=1. DISPENSE -> IDLE when run=0. The drop timer clears on every entry to DISPENSE.
- In DISPENSE, a drop fires when the drop timer reaches its period − 1 and starve=0. A drop does the following: start a PULSE_MS high pulse on hopper_level, decrement pills_left, and increment fill_cnt (saturating).
- If starve=1 at the expiry point, the timer holds at its period − 1. The drop fires on the first cycle with starve=0.
- When pills_left reaches 0 after a drop, the block goes to EMPTY. No further drops occur until refill.
- EMPTY -> IDLE on refill.
- refill in any state sets pills_left=HOPPER_CAP. If a drop fires in the same cycle, pills_left=HOPPER_CAP−1.
- switch_req in IDLE or DISPENSE -> SWITCH. It takes priority over a drop due in the same cycle; that drop is not emitted. switch_req is ignored in SWITCH, EMPTY and JAMMED.
- On entry to SWITCH: conveyor_signal=0, bottle_busy=1, and a travel counter loads SWITCH_MS−1.
- When the travel counter reaches 0:
  - If jam=1, go to JAMMED.
  - Otherwise complete the switch: bottles_out+1 (saturating), fill_cnt=0, conveyor_signal=1, bottle_busy=0. Then go to DISPENSE if run=1, else IDLE.
- JAMMED: conveyor_signal stays 0. When jam falls, complete the switch as above and go to IDLE.
- A hopper pulse already in progress always completes its full PULSE_MS, whatever the state changes.

## Timing
- Reset values:
  - state IDLE, all counters cleared
  - hopper_level 0, conveyor_signal 1, bottle_busy 0
  - pills_left HOPPER_CAP, fill_cnt 0, bottles_out 0, plant_state 0
- All outputs are registered; there is no combinational path from inputs to outputs.
- First drop comes DROP_PERIOD_MS cycles after the DISPENSE entry cycle. hopper_level rises on the cycle after the expiry point. pills_left and fill_cnt update in that same cycle.
- conveyor_signal falls 1 cycle after switch_req. It rises exactly SWITCH_MS cycles after it fell when not jammed.
- clr asserted mid-pulse or mid-switch forces reset values on the next edge.

## Configuration
- PLANT_JITTER_EN defined: the drop period varies per drop and equals DROP_PERIOD_MS − 64 + lfsr[6:0].
  - LFSR: 8-bit, x^8+x^6+x^5+x^4+1, seed 8'h01 on clr.
  - It advances once per emitted drop.
- PLANT_JITTER_EN undefined: the period is exactly DROP_PERIOD_MS, and no LFSR logic is present.

## Structure
- Shared package pill_pkg holds:
  - the plant state encoding
  - the BCD saturation limits (999, 99)
  - the LFSR seed and taps
  - the controller's state encoding is kept alongside these
- One sub-module, pill_lfsr8 (enable, clr, 8-bit state), instantiated only under PLANT_JITTER_EN.

## Test plan
- Reset, run=1 held: rising edges of hopper_level at cycles 1000, 2000 and 3000 after DISPENSE entry; each pulse is 10 cycles wide; pills_left goes 199, 198, 197.
- HOPPER_CAP=3, run=1: after the 3rd drop plant_state=3 and no more edges occur; refill gives pills_left=3 and plant_state=0, and drops resume once run is seen.
- switch_req in the same cycle a drop is due: no pulse is emitted; conveyor_signal is low for exactly 2000 cycles; then bottles_out=1, fill_cnt=0.
- jam=1 during a switch: conveyor_signal stays 0 past 2000 cycles and plant_state=4; release jam -> conveyor_signal=1 next cycle, plant_state=0, bottles_out+1.
- starve=1 for 500 cycles across a drop point: that drop is delayed by 500 cycles; no pills are lost.
- clr in the middle of a pulse and a switch: all outputs match the reset values on the next cycle; with PLANT_JITTER_EN, the first two drop intervals match a reference model of the LFSR seeded with 8'h01.

Source files
------------

// File: rtl/pill_pkg.sv
// Shared definitions for the bottling line: plant state encoding, BCD
// display saturation limits, jitter LFSR seed/taps, controller encoding.
package pill_pkg;

    // Plant state encoding, also driven on plant_state for the display mux
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DISPENSE = 3'd1;
    localparam logic [2:0] ST_SWITCH   = 3'd2;
    localparam logic [2:0] ST_EMPTY    = 3'd3;
    localparam logic [2:0] ST_JAMMED   = 3'd4;

    // Bottling controller state encoding, kept here so both sides agree
    localparam logic [1:0] CTRL_IDLE   = 2'd0;
    localparam logic [1:0] CTRL_FILL   = 2'd1;
    localparam logic [1:0] CTRL_SWITCH = 2'd2;
    localparam logic [1:0] CTRL_FAULT  = 2'd3;

    // Counters saturate at the largest value the BCD displays can show
    localparam logic [9:0] FILL_LIMIT   = 10'd999;
    localparam logic [6:0] BOTTLE_LIMIT = 7'd99;

    // Jitter LFSR: x^8+x^6+x^5+x^4+1, shifting left, feedback into bit 0
    localparam logic [7:0] LFSR_SEED = 8'h01;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/pill_plant_sim_if.sv
// Controller/switch-side bundle of the plant model. The master drives the
// requests and faults, the slave (the plant) drives the sensor outputs.
interface pill_plant_sim_if;

    logic       run;
    logic       switch_req;
    logic       refill;
    logic       starve;
    logic       jam;
    logic       hopper_level;
    logic       conveyor_signal;
    logic       bottle_busy;
    logic [7:0] pills_left;
    logic [9:0] fill_cnt;
    logic [6:0] bottles_out;
    logic [2:0] plant_state;

    modport master (
        output run, switch_req, refill, starve, jam,
        input  hopper_level, conveyor_signal, bottle_busy,
        input  pills_left, fill_cnt, bottles_out, plant_state
    );

    modport slave (
        input  run, switch_req, refill, starve, jam,
        output hopper_level, conveyor_signal, bottle_busy,
        output pills_left, fill_cnt, bottles_out, plant_state
    );

endinterface

// File: rtl/pill_lfsr8.sv
// 8-bit Fibonacci LFSR used to jitter the pill drop period; advances once
// per enable, reseeds on clr.
module pill_lfsr8
    import pill_pkg::*;
(
    input  logic       clk_1khz,
    input  logic       clr,
    input  logic       enable,
    output logic [7:0] state
);

    // Step the sequence on each enabled cycle
    always_ff @(posedge clk_1khz) begin
        if (clr)
            state <= LFSR_SEED;
        else if (enable)
            state <= lfsr8_next(state);
    end

endmodule

// File: rtl/pill_plant_sim.sv
// Plant model for the bottling line: hopper gate (drop pulses, pill count)
// and bottle conveyor (switch travel, jam handling). All outputs registered.
// Optional macro PLANT_JITTER_EN: drop period = DROP_PERIOD_MS-64+lfsr[6:0].
module pill_plant_sim
    import pill_pkg::*;
#(
    parameter int unsigned DROP_PERIOD_MS = 1000,
    parameter int unsigned PULSE_MS       = 10,
    parameter int unsigned HOPPER_CAP     = 200,
    parameter int unsigned SWITCH_MS      = 2000
)
(
    input  logic             clk_1khz,
    input  logic             clr,
    pill_plant_sim_if.slave  bus
);

    localparam int unsigned TW  = $clog2(DROP_PERIOD_MS + 64);
    localparam int unsigned SWW = $clog2(SWITCH_MS + 1);
    localparam int unsigned PW  = $clog2(PULSE_MS + 1);

    logic [2:0]     state_q;
    logic [TW-1:0]  drop_timer_q;
    logic [TW-1:0]  period_m1;
    logic [SWW-1:0] travel_q;
    logic [PW-1:0]  pulse_cnt_q;
    logic           hopper_q;
    logic           conveyor_q;
    logic           busy_q;
    logic [7:0]     pills_q;
    logic [7:0]     pills_next;
    logic [9:0]     fill_q;
    logic [6:0]     bottles_q;
    logic           drop_fire;
    logic           enter_switch;
    logic           switch_done;

`ifdef PLANT_JITTER_EN
    logic [7:0] lfsr;

    pill_lfsr8 u_lfsr (
        .clk_1khz (clk_1khz),
        .clr      (clr),
        .enable   (drop_fire),
        .state    (lfsr)
    );

    // Period only changes on a drop, when the timer restarts from zero
    always_comb period_m1 = TW'(DROP_PERIOD_MS - 65) + TW'(lfsr[6:0]);
`else
    // Fixed drop period
    always_comb period_m1 = TW'(DROP_PERIOD_MS - 1);
`endif

    // Event decode: a switch request beats a drop due in the same cycle,
    // and leaving DISPENSE (run low) also cancels it
    always_comb begin
        enter_switch = bus.switch_req &&
                       (state_q == ST_IDLE || state_q == ST_DISPENSE);
        drop_fire    = (state_q == ST_DISPENSE) && bus.run && !bus.switch_req &&
                       (drop_timer_q == period_m1) && !bus.starve;
        switch_done  = ((state_q == ST_SWITCH) && (travel_q == '0) && !bus.jam) ||
                       ((state_q == ST_JAMMED) && !bus.jam);
    end

    // Hopper count after this cycle's refill and/or drop
    always_comb begin
        pills_next = bus.refill ? 8'(HOPPER_CAP) : pills_q;
        if (drop_fire)
            pills_next = pills_next - 8'd1;
    end

    // Main plant state machine with drop timer and switch travel counter
    always_ff @(posedge clk_1khz) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            drop_timer_q <= '0;
            travel_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.switch_req) begin
                        state_q  <= ST_SWITCH;
                        travel_q <= SWW'(SWITCH_MS - 1);
                    end else if (bus.run) begin
                        state_q      <= ST_DISPENSE;
                        drop_timer_q <= '0;
                    end
                end
                ST_DISPENSE: begin
                    if (bus.switch_req) begin
                        state_q  <= ST_SWITCH;
                        travel_q <= SWW'(SWITCH_MS - 1);
                    end else if (!bus.run) begin
                        state_q <= ST_IDLE;
                    end else if (drop_fire) begin
                        drop_timer_q <= '0;
                        if (pills_next == 8'd0)
                            state_q <= ST_EMPTY;
                    end else if (drop_timer_q != period_m1) begin
                        // holds at period-1 while starved
                        drop_timer_q <= drop_timer_q + 1'b1;
                    end
                end
                ST_SWITCH: begin
                    if (travel_q == '0) begin
                        if (bus.jam) begin
                            state_q <= ST_JAMMED;
                        end else if (bus.run) begin
                            state_q      <= ST_DISPENSE;
                            drop_timer_q <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        travel_q <= travel_q - 1'b1;
                    end
                end
                ST_EMPTY: begin
                    if (bus.refill)
                        state_q <= ST_IDLE;
                end
                ST_JAMMED: begin
                    if (!bus.jam)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Hopper pulse: once started it runs its full width regardless of state
    always_ff @(posedge clk_1khz) begin
        if (clr) begin
            hopper_q    <= 1'b0;
            pulse_cnt_q <= '0;
        end else if (drop_fire) begin
            hopper_q    <= 1'b1;
            pulse_cnt_q <= PW'(PULSE_MS - 1);
        end else if (hopper_q) begin
            if (pulse_cnt_q == '0)
                hopper_q <= 1'b0;
            else
                pulse_cnt_q <= pulse_cnt_q - 1'b1;
        end
    end

    // Pill, fill and bottle counters
    always_ff @(posedge clk_1khz) begin
        if (clr) begin
            pills_q   <= 8'(HOPPER_CAP);
            fill_q    <= '0;
            bottles_q <= '0;
        end else begin
            pills_q <= pills_next;
            if (switch_done)
                fill_q <= '0;
            else if (drop_fire && fill_q != FILL_LIMIT)
                fill_q <= fill_q + 10'd1;
            if (switch_done && bottles_q != BOTTLE_LIMIT)
                bottles_q <= bottles_q + 7'd1;
        end
    end

    // Conveyor status: bottle leaves on switch entry, returns on completion
    always_ff @(posedge clk_1khz) begin
        if (clr) begin
            conveyor_q <= 1'b1;
            busy_q     <= 1'b0;
        end else if (enter_switch) begin
            conveyor_q <= 1'b0;
            busy_q     <= 1'b1;
        end else if (switch_done) begin
            conveyor_q <= 1'b1;
            busy_q     <= 1'b0;
        end
    end

    assign bus.hopper_level    = hopper_q;
    assign bus.conveyor_signal = conveyor_q;
    assign bus.bottle_busy     = busy_q;
    assign bus.pills_left      = pills_q;
    assign bus.fill_cnt        = fill_q;
    assign bus.bottles_out     = bottles_q;
    assign bus.plant_state     = state_q;

endmodule
